ila_capture_ctrl: RTL and testbench

Capture sequencer for the ILA. It combines N_TRIG per-signal trigger-slice outputs into one trigger event and runs the arm, pre-trigger, post-trigger and done sequence. It drives write enable and address of the circular sample buffer, and reports where the trigger landed. It sits between the trigger-slice array and the sample RAM and is programmed from the ILA register file.

---
 rtl/ila_capture_ctrl.sv | 143 ++++++++++++++
 tb/tb_ila_capture_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl
// ----------------
// Capture sequencer for the ILA. Combines the trigger-slice outputs into a
// single trigger event, walks the IDLE -> ARMED -> POST -> DONE sequence and
// drives the circular sample buffer write port.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   arm, disarm   single-cycle control pulses (disarm wins when both are set)
//   sample_en     qualifier for buffer writes and trigger evaluation
//   trig_vec      trigger-slice outputs
//   reduce_type   0 = OR-reduce trig_vec, 1 = AND-reduce trig_vec
//   post_count    samples stored after the trigger sample, latched at trigger
//   buf_we        buffer write enable (combinational)
//   buf_waddr     buffer write address (registered write pointer)
//   armed         state is ARMED or POST
//   triggered     a trigger occurred in the current capture
//   done          state is DONE
//   trig_addr     buffer address of the trigger sample
//   n_samples     writes since arm, saturating at 2^ADDR_W
//   dbg_state     raw FSM state (0 IDLE, 1 ARMED, 2 POST, 3 DONE)
//
// Handshake note: there is no backpressure. A buffer write happens on every
// cycle where buf_we is 1; the RAM is expected to accept it unconditionally.
module ila_capture_ctrl #(
  parameter int N_TRIG = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              disarm,
  input  logic              sample_en,
  input  logic [N_TRIG-1:0] trig_vec,
  input  logic              reduce_type,
  input  logic [ADDR_W-1:0] post_count,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W:0]   n_samples,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W:0]   n_samples_q, n_samples_d;
  logic              triggered_q, triggered_d;
  logic              trig_hit;
  logic              we;

  always_comb begin
    trig_hit = (reduce_type ? (&trig_vec) : (|trig_vec)) & sample_en;
    we       = sample_en & ((state_q == S_ARMED) | (state_q == S_POST));

    state_d     = state_q;
    wptr_d      = wptr_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    n_samples_d = n_samples_q;
    triggered_d = triggered_q;

    if (disarm) begin
      // Abort: counters and the trigger flag stay readable afterwards.
      state_d = S_IDLE;
    end else if (arm) begin
      // Restart from any state; trig_vec is deliberately not looked at here.
      state_d     = S_ARMED;
      wptr_d      = '0;
      n_samples_d = '0;
      triggered_d = 1'b0;
    end else begin
      if (we) begin
        wptr_d = wptr_q + ADDR_W'(1);
        if (n_samples_q != DEPTH) n_samples_d = n_samples_q + (ADDR_W+1)'(1);
      end
      case (state_q)
        S_ARMED: begin
          // trig_hit implies a write this cycle, so the trigger sample is
          // stored at the current wptr.
          if (trig_hit) begin
            trig_addr_d = wptr_q;
            triggered_d = 1'b1;
            if (post_count == '0) begin
              state_d = S_DONE;
            end else begin
              post_cnt_d = post_count;
              state_d    = S_POST;
            end
          end
        end
        S_POST: begin
          if (we) begin
            if (post_cnt_q == ADDR_W'(1)) state_d = S_DONE;
            post_cnt_d = post_cnt_q - ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      n_samples_q <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      n_samples_q <= n_samples_d;
      triggered_q <= triggered_d;
    end
  end

  assign buf_we    = we;
  assign buf_waddr = wptr_q;
  assign armed     = (state_q == S_ARMED) | (state_q == S_POST);
  assign done      = (state_q == S_DONE);
  assign triggered = triggered_q;
  assign trig_addr = trig_addr_q;
  assign n_samples = n_samples_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
module tb_ila_capture_ctrl;

  localparam int N_TRIG = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_POST  = 2;
  localparam int M_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              arm, disarm, sample_en, reduce_type;
  logic [N_TRIG-1:0] trig_vec;
  logic [ADDR_W-1:0] post_count;
  logic              buf_we, armed, triggered, done;
  logic [ADDR_W-1:0] buf_waddr, trig_addr;
  logic [ADDR_W:0]   n_samples;
  logic [1:0]        dbg_state;

  ila_capture_ctrl #(.N_TRIG(N_TRIG), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .sample_en(sample_en),
    .trig_vec(trig_vec), .reduce_type(reduce_type), .post_count(post_count),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .armed(armed),
    .triggered(triggered), .done(done), .trig_addr(trig_addr),
    .n_samples(n_samples), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic mon_en = 1'b0;
  int exp_we, exp_armed, exp_done, exp_trig, exp_taddr, exp_ns;

  // ---------------- reference model ----------------
  // Captures are described by a count of writes since arm; the address and
  // the sample count are derived from it with modulo / saturation.
  int m_mode, m_writes, m_post_left, m_trig_addr, m_trig;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_writes = 0; m_post_left = 0; m_trig_addr = 0; m_trig = 0;
  endtask

  task automatic model_step(input logic a, input logic d, input logic se,
                            input logic [N_TRIG-1:0] tv, input logic rt,
                            input logic [ADDR_W-1:0] pc);
    bit wr, hit;
    wr  = se && (m_mode == M_ARMED || m_mode == M_POST);
    hit = rt ? (tv == {N_TRIG{1'b1}}) : (tv != 0);
    if (d) m_mode = M_IDLE;
    else if (a) begin
      m_mode = M_ARMED; m_writes = 0; m_trig = 0;
    end else if (wr) begin
      if (m_mode == M_ARMED && hit) begin
        m_trig_addr = m_writes % DEPTH;
        m_trig = 1;
        if (pc == 0) m_mode = M_DONE;
        else begin m_post_left = int'(pc); m_mode = M_POST; end
      end else if (m_mode == M_POST) begin
        m_post_left--;
        if (m_post_left == 0) m_mode = M_DONE;
      end
      m_writes++;
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drives one cycle of inputs, records what the DUT must
  // show during this cycle, then advances the model across the next edge.
  task automatic cyc(input logic a, input logic d, input logic se,
                     input logic [N_TRIG-1:0] tv, input logic rt,
                     input logic [ADDR_W-1:0] pc);
    arm = a; disarm = d; sample_en = se; trig_vec = tv;
    reduce_type = rt; post_count = pc;
    exp_we    = (se && (m_mode == M_ARMED || m_mode == M_POST)) ? 1 : 0;
    exp_armed = (m_mode == M_ARMED || m_mode == M_POST) ? 1 : 0;
    exp_done  = (m_mode == M_DONE) ? 1 : 0;
    exp_trig  = m_trig;
    exp_taddr = m_trig_addr;
    exp_ns    = (m_writes > DEPTH) ? DEPTH : m_writes;
    if (exp_we == 1) exp_q.push_back(ADDR_W'(m_writes % DEPTH));
    @(posedge clk);
    model_step(a, d, se, tv, rt, pc);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_buf_we"}, buf_we, 0);
    check({tag, "_buf_waddr"}, buf_waddr, 0);
    check({tag, "_armed"}, armed, 0);
    check({tag, "_triggered"}, triggered, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_trig_addr"}, trig_addr, 0);
    check({tag, "_n_samples"}, n_samples, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("buf_we", buf_we, exp_we);
      if (buf_we) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL write_addr actual=%0d expected=none t=%0t", buf_waddr, $time);
        end else begin
          check("buf_waddr", buf_waddr, exp_q.pop_front());
        end
      end
      check("armed", armed, exp_armed);
      check("done", done, exp_done);
      check("triggered", triggered, exp_trig);
      check("trig_addr", trig_addr, exp_taddr);
      check("n_samples", n_samples, exp_ns);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; arm = 0; disarm = 0; sample_en = 0; trig_vec = '0;
    reduce_type = 0; post_count = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // 1: OR reduce, trigger on 6th sample, 3 post samples
    cyc(1, 0, 0, 4'b0000, 0, 4'd3);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'b0000, 0, 4'd3);
    cyc(0, 0, 1, 4'b0001, 0, 4'd3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'b0000, 0, 4'd3);
    check("t1_trig_addr", trig_addr, 5);
    check("t1_n_samples", n_samples, 9);
    check("t1_done", done, 1);
    idle(2);

    // 2: AND reduce, partial match for 20 samples, wrapped trigger
    cyc(1, 0, 0, 4'b0000, 1, 4'd0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 4'b0111, 1, 4'd0);
    check("t2_no_trig", triggered, 0);
    cyc(0, 0, 1, 4'b1111, 1, 4'd0);
    check("t2_trig_addr", trig_addr, 4);
    check("t2_n_samples", n_samples, 16);
    check("t2_done", done, 1);
    idle(2);

    // 3: sample_en toggling, trigger pulses on unqualified cycles ignored
    cyc(1, 0, 0, 4'b0000, 0, 4'd2);
    for (int i = 0; i < 6; i++)
      cyc(0, 0, (i % 2 == 0), (i % 2 == 0) ? 4'b0000 : 4'b0001, 0, 4'd2);
    check("t3_no_trig", triggered, 0);
    cyc(0, 0, 1, 4'b0001, 0, 4'd2);
    for (int i = 0; i < 4; i++) cyc(0, 0, (i % 2 == 1), 4'b0000, 0, 4'd2);
    check("t3_done", done, 1);
    check("t3_trig_addr", trig_addr, 3);
    check("t3_n_samples", n_samples, 6);

    // 4: arm+disarm together, then disarm during POST
    cyc(0, 1, 0, 4'b0000, 0, 4'd0);
    cyc(1, 1, 1, 4'b1111, 0, 4'd0);
    check("t4_stay_idle", armed, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'b1111, 0, 4'd0);
    cyc(1, 0, 0, 4'b0000, 0, 4'd5);
    cyc(0, 0, 1, 4'b0000, 0, 4'd5);
    cyc(0, 0, 1, 4'b0010, 0, 4'd5);
    cyc(0, 0, 1, 4'b0000, 0, 4'd5);
    cyc(0, 1, 0, 4'b0000, 0, 4'd5);
    check("t4_abort_armed", armed, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_triggered", triggered, 1);
    check("t4_abort_n_samples", n_samples, 3);

    // 5: re-arm from DONE with trig_vec high in the arm cycle
    cyc(1, 0, 0, 4'b0000, 0, 4'd1);
    cyc(0, 0, 1, 4'b1000, 0, 4'd1);
    cyc(0, 0, 1, 4'b0000, 0, 4'd1);
    check("t5_done", done, 1);
    cyc(1, 0, 1, 4'b1111, 0, 4'd0);
    check("t5_rearm_armed", armed, 1);
    check("t5_rearm_triggered", triggered, 0);
    check("t5_rearm_n_samples", n_samples, 0);
    cyc(0, 0, 1, 4'b1111, 0, 4'd0);
    check("t5_trig_addr", trig_addr, 0);
    check("t5_n_samples", n_samples, 1);

    // 6: asynchronous reset during POST, then a clean capture
    cyc(1, 0, 0, 4'b0000, 0, 4'd4);
    cyc(0, 0, 1, 4'b0000, 0, 4'd4);
    cyc(0, 0, 1, 4'b0100, 0, 4'd4);
    cyc(0, 0, 1, 4'b0000, 0, 4'd4);
    mon_en = 1'b0;
    sample_en = 1'b1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("midrst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    mon_en = 1'b1;
    cyc(1, 0, 0, 4'b0000, 0, 4'd2);
    cyc(0, 0, 1, 4'b0000, 0, 4'd2);
    cyc(0, 0, 1, 4'b0000, 0, 4'd2);
    cyc(0, 0, 1, 4'b1100, 0, 4'd2);
    cyc(0, 0, 1, 4'b0000, 0, 4'd2);
    cyc(0, 0, 1, 4'b0000, 0, 4'd2);
    check("t6_trig_addr", trig_addr, 2);
    check("t6_n_samples", n_samples, 5);
    check("t6_done", done, 1);

    // random: control pulses are issued on unqualified cycles
    for (int i = 0; i < 600; i++) begin
      logic a, d, se, rt;
      logic [N_TRIG-1:0] tv;
      logic [ADDR_W-1:0] pc;
      a  = ($urandom_range(0, 29) == 0);
      d  = ($urandom_range(0, 59) == 0);
      se = ($urandom_range(0, 9) < 7);
      if (a || d) se = 1'b0;
      rt = ($urandom_range(0, 1) == 1);
      tv = N_TRIG'($urandom_range(0, (1 << N_TRIG) - 1));
      if ($urandom_range(0, 3) != 0) tv = rt ? {N_TRIG{1'b0}} : {N_TRIG{1'b0}};
      pc = ($urandom_range(0, 7) == 0) ? ADDR_W'(DEPTH - 1)
                                       : ADDR_W'($urandom_range(0, 6));
      cyc(a, d, se, tv, rt, pc);
    end
    idle(2);

    check("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
